// File: rtl/cv32e40x_div_sched_if.sv
// EX-side request/result channel of the divide scheduler.
// Scheduler takes the slave modport, EX the master.
interface cv32e40x_div_sched_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_operator_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic        req_dit_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;

  modport master (
    output req_valid_i,
    output req_operator_i,
    output req_op_a_i,
    output req_op_b_i,
    output req_dit_i,
    output res_ready_i,
    input  req_ready_o,
    input  res_valid_o,
    input  res_data_o
  );

  modport slave (
    input  req_valid_i,
    input  req_operator_i,
    input  req_op_a_i,
    input  req_op_b_i,
    input  req_dit_i,
    input  res_ready_i,
    output req_ready_o,
    output res_valid_o,
    output res_data_o
  );
endinterface

// File: rtl/cv32e40x_div_sched.sv
// Divide issue/sequencing controller between EX and the serial divider.
// Holds operands for the whole divide; one-entry cache answers repeats.
module cv32e40x_div_sched #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cv32e40x_div_sched_if.slave        ex,
  input  logic                       kill_i,
  input  logic                       cache_flush_i,
  output logic                       div_en_o,
  output logic                       div_valid_o,
  output logic [1:0]                 div_operator_o,
  output logic [31:0]                div_op_a_o,
  output logic [31:0]                div_op_b_o,
  output logic                       div_dit_o,
  output logic                       div_ready_o,
  input  logic                       div_valid_i,
  input  logic [31:0]                div_result_i
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HIT,
    DONE
  } state_e;

  state_e      state;
  logic        rdy_q;
  logic        run_q;
  logic        out_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        dit_q;
  logic [31:0] res_q;

  logic        c_v;
  logic [1:0]  c_op;
  logic [31:0] c_a;
  logic [31:0] c_b;
  logic [31:0] c_res;

  logic        key_eq;
  logic        hit;
  logic        div_hs;
  logic        fill;

  assign key_eq = {ex.req_operator_i, ex.req_op_a_i, ex.req_op_b_i}
               == {c_op, c_a, c_b};

  // DIT requests bypass the cache so their timing never depends on data.
  assign hit = CACHE_EN && c_v && !ex.req_dit_i && key_eq;

  assign div_hs = run_q && div_valid_i && !kill_i;
  assign fill   = CACHE_EN && div_hs && !dit_q;

  // Sequencing FSM; flags are registered, kill masks them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b1;
      run_q <= 1'b0;
      out_q <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      dit_q <= 1'b0;
      res_q <= '0;
    end else if (kill_i) begin
      state <= IDLE;
      rdy_q <= 1'b1;
      run_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex.req_valid_i) begin
            op_q  <= ex.req_operator_i;
            a_q   <= ex.req_op_a_i;
            b_q   <= ex.req_op_b_i;
            dit_q <= ex.req_dit_i;
            rdy_q <= 1'b0;
            if (hit) begin
              state <= HIT;
              res_q <= c_res;
              out_q <= 1'b1;
            end else begin
              state <= RUN;
              run_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (div_valid_i) begin
            state <= DONE;
            res_q <= div_result_i;
            run_q <= 1'b0;
            out_q <= 1'b1;
          end
        end
        HIT, DONE: begin
          if (ex.res_ready_i) begin
            state <= IDLE;
            out_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          run_q <= 1'b0;
          out_q <= 1'b0;
        end
      endcase
    end
  end

  // Result cache; a flush in the same cycle as a fill wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_v   <= 1'b0;
      c_op  <= '0;
      c_a   <= '0;
      c_b   <= '0;
      c_res <= '0;
    end else begin
      if (fill) begin
        c_v   <= 1'b1;
        c_op  <= op_q;
        c_a   <= a_q;
        c_b   <= b_q;
        c_res <= div_result_i;
      end
      if (cache_flush_i) begin
        c_v <= 1'b0;
      end
    end
  end

  assign ex.req_ready_o = rdy_q;
  assign ex.res_valid_o = out_q && !kill_i;
  assign ex.res_data_o  = res_q;

  assign div_en_o       = run_q;
  assign div_valid_o    = run_q && !kill_i;
  assign div_ready_o    = div_hs;
  assign div_operator_o = op_q;
  assign div_op_a_o     = a_q;
  assign div_op_b_o     = b_q;
  assign div_dit_o      = dit_q;

  a_no_stray_div_valid: assert property (
    @(posedge clk) disable iff (!rst_n) div_valid_i |-> run_q
  );

endmodule

// File: tb/tb_cv32e40x_div_sched.sv
// Randomized bench for the divide scheduler with a behavioural divider
// and a reference model of the one-entry result cache.
module tb_cv32e40x_div_sched;

  localparam logic [1:0] OP_DIVU = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_REMU = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        dit;
    logic        fl_acc;
    logic        fl_hs;
    logic        pulse;
    logic [3:0]  stall;
    logic        hit;
    logic [31:0] lit;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        kill_i;
  logic        cache_flush_i;
  logic        div_en_o;
  logic        div_valid_o;
  logic [1:0]  div_operator_o;
  logic [31:0] div_op_a_o;
  logic [31:0] div_op_b_o;
  logic        div_dit_o;
  logic        div_ready_o;
  logic        dv;
  logic [31:0] dres;
  logic        busy;
  int          cnt;
  int          lat_force;

  int vectors;
  int errors;

  bit          mv;
  logic [1:0]  mop;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] mres;

  cv32e40x_div_sched_if ex ();

  cv32e40x_div_sched #(.CACHE_EN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex             (ex),
    .kill_i         (kill_i),
    .cache_flush_i  (cache_flush_i),
    .div_en_o       (div_en_o),
    .div_valid_o    (div_valid_o),
    .div_operator_o (div_operator_o),
    .div_op_a_o     (div_op_a_o),
    .div_op_b_o     (div_op_b_o),
    .div_dit_o      (div_dit_o),
    .div_ready_o    (div_ready_o),
    .div_valid_i    (dv),
    .div_result_i   (dres)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] r;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: r = (b == 0) ? a : a % b;
      OP_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      default: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else r = 32'(sa % sb);
      end
    endcase
    return r;
  endfunction

  // Behavioural serial divider: variable latency, drops out when valid falls.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv   <= 1'b0;
      dres <= '0;
      busy <= 1'b0;
      cnt  <= 0;
    end else if (!div_valid_o) begin
      dv   <= 1'b0;
      busy <= 1'b0;
    end else if (dv) begin
      if (div_ready_o) begin
        dv   <= 1'b0;
        busy <= 1'b0;
      end
    end else if (!busy) begin
      busy <= 1'b1;
      cnt  <= (lat_force != 0) ? lat_force :
              (div_dit_o ? 12 : int'($urandom_range(6, 1)));
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end else begin
      dv   <= 1'b1;
      dres <= ref_div(div_operator_o, div_op_a_o, div_op_b_o);
    end
  end

  // Cache reference: predicts hit and updates the single entry.
  function automatic bit model_step(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
    input bit dit, input bit fl_acc, input bit fl_hs);
    bit h;
    h = mv && !dit && op == mop && a == ma && b == mb;
    if (fl_acc) mv = 1'b0;
    if (!h && fl_hs) mv = 1'b0;
    if (!h && !dit && !fl_hs) begin
      mv   = 1'b1;
      mop  = op;
      ma   = a;
      mb   = b;
      mres = ref_div(op, a, b);
    end
    return h;
  endfunction

  task automatic pulse_flush();
    cache_flush_i = 1'b1;
    @(posedge clk); #1;
    cache_flush_i = 1'b0;
    mv = 1'b0;
  endtask

  task automatic start_req(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
    input bit dit);
    int k;
    k = 0;
    while (!ex.req_ready_o && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    ex.req_valid_i    = 1'b1;
    ex.req_operator_i = op;
    ex.req_op_a_i     = a;
    ex.req_op_b_i     = b;
    ex.req_dit_i      = dit;
    @(posedge clk); #1;
    ex.req_valid_i = 1'b0;
  endtask

  // Drives one full transaction and reports what was observed.
  task automatic run_op(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
    input bit dit, input bit fl_acc, input bit fl_hs, input int stall,
    output logic [31:0] res, output bit ran, output int lat,
    output bit ok);
    int k;
    int hs;
    ok  = 1'b1;
    ran = 1'b0;
    hs  = -1;
    k   = 0;
    while (!ex.req_ready_o && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ex.req_ready_o) ok = 1'b0;
    ex.req_valid_i    = 1'b1;
    ex.req_operator_i = op;
    ex.req_op_a_i     = a;
    ex.req_op_b_i     = b;
    ex.req_dit_i      = dit;
    cache_flush_i     = fl_acc;
    @(posedge clk); #1;
    ex.req_valid_i = 1'b0;
    cache_flush_i  = 1'b0;
    k = 1;
    while (!ex.res_valid_o && k < 200) begin
      if (div_en_o) begin
        ran = 1'b1;
        if (!div_valid_o || div_op_a_o !== a || div_op_b_o !== b ||
            div_operator_o !== op || div_dit_o !== dit) ok = 1'b0;
      end
      if (dv && !div_ready_o) ok = 1'b0;
      if (dv && div_ready_o) begin
        hs = k;
        cache_flush_i = fl_hs;
      end
      @(posedge clk); #1;
      cache_flush_i = 1'b0;
      k++;
    end
    lat = k;
    if (!ex.res_valid_o) ok = 1'b0;
    if (ran && lat != hs + 1) ok = 1'b0;
    if (!ran && lat != 1) ok = 1'b0;
    res = ex.res_data_o;
    for (int i = 0; i < stall; i++) begin
      if (ex.req_ready_o !== 1'b0 || ex.res_valid_o !== 1'b1 ||
          ex.res_data_o !== res || div_en_o !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    ex.res_ready_i = 1'b1;
    @(posedge clk); #1;
    ex.res_ready_i = 1'b0;
    if (ex.res_valid_o !== 1'b0 || ex.req_ready_o !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({ex.req_ready_o, ex.res_valid_o, div_en_o, div_valid_o,
         div_ready_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctl: got %b, required 10000",
        {ex.req_ready_o, ex.res_valid_o, div_en_o, div_valid_o,
         div_ready_o});
    end
    vectors++;
    if ({ex.res_data_o, div_op_a_o, div_op_b_o, div_operator_o,
         div_dit_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: res=%h a=%h b=%h op=%0d dit=%0d, required 0",
        ex.res_data_o, div_op_a_o, div_op_b_o, div_operator_o, div_dit_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ex.req_ready_o !== 1'b1 || ex.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%0d res_valid=%0d, required 1 0",
        ex.req_ready_o, ex.res_valid_o);
    end
  endtask

  task automatic test_fill_hit();
    vec_t t[6];
    logic [31:0] res;
    bit ran;
    bit ok;
    int lat;
    t[0] = '{OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
             1'b0, 32'd14};
    t[1] = '{OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
             1'b1, 32'd14};
    t[2] = '{OP_REMU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
             1'b0, 32'd2};
    t[3] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
             1'b0, 32'hFFFF_FFFD};
    t[4] = '{OP_DIV, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
             1'b0, 32'hFFFF_FFFF};
    t[5] = '{OP_DIV, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,
             1'b1, 32'hFFFF_FFFF};
    foreach (t[i]) begin
      void'(model_step(t[i].op, t[i].a, t[i].b, 1'b0, 1'b0, 1'b0));
      run_op(t[i].op, t[i].a, t[i].b, 1'b0, 1'b0, 1'b0, 0,
             res, ran, lat, ok);
      vectors++;
      if (!ok || res !== t[i].lit || ran !== !t[i].hit) begin
        errors++;
        $display("FAIL fill_hit[%0d]: res=%h ran=%0d lat=%0d ok=%0d, required res=%h ran=%0d",
          i, res, ran, lat, ok, t[i].lit, !t[i].hit);
      end
    end
  endtask

  task automatic test_dit();
    vec_t t[5];
    logic [31:0] res;
    logic [31:0] exp;
    bit ran;
    bit ok;
    bit h;
    int lat;
    t[0] = '{OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[1] = '{OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[2] = '{OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[3] = '{OP_DIVU, 32'd33, 32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[4] = '{OP_DIVU, 32'd33, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    foreach (t[i]) begin
      h   = model_step(t[i].op, t[i].a, t[i].b, t[i].dit, 1'b0, 1'b0);
      exp = ref_div(t[i].op, t[i].a, t[i].b);
      run_op(t[i].op, t[i].a, t[i].b, t[i].dit, 1'b0, 1'b0, 0,
             res, ran, lat, ok);
      vectors++;
      if (!ok || res !== exp || ran !== !h) begin
        errors++;
        $display("FAIL dit[%0d]: res=%h ran=%0d lat=%0d ok=%0d, required res=%h ran=%0d",
          i, res, ran, lat, ok, exp, !h);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] res;
    logic [31:0] exp;
    bit ran;
    bit ok;
    bit h;
    int lat;
    exp = ref_div(OP_DIVU, 32'd1234, 32'd5);
    for (int i = 0; i < 2; i++) begin
      h = model_step(OP_DIVU, 32'd1234, 32'd5, 1'b0, 1'b0, 1'b0);
      run_op(OP_DIVU, 32'd1234, 32'd5, 1'b0, 1'b0, 1'b0, 10,
             res, ran, lat, ok);
      vectors++;
      if (!ok || res !== exp || ran !== !h) begin
        errors++;
        $display("FAIL stall[%0d]: res=%h ran=%0d ok=%0d, required res=%h ran=%0d",
          i, res, ran, ok, exp, !h);
      end
    end
  endtask

  task automatic test_flush();
    vec_t t[7];
    logic [31:0] res;
    logic [31:0] exp;
    bit ran;
    bit ok;
    bit h;
    int lat;
    t[0] = '{OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[1] = '{OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 32'd0};
    t[2] = '{OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[3] = '{OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[4] = '{OP_DIVU, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    t[5] = '{OP_REM, 32'd50, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0};
    t[6] = '{OP_REM, 32'd50, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
    foreach (t[i]) begin
      if (t[i].pulse) pulse_flush();
      h   = model_step(t[i].op, t[i].a, t[i].b, 1'b0, t[i].fl_acc,
                        t[i].fl_hs);
      exp = ref_div(t[i].op, t[i].a, t[i].b);
      run_op(t[i].op, t[i].a, t[i].b, 1'b0, t[i].fl_acc, t[i].fl_hs, 0,
             res, ran, lat, ok);
      vectors++;
      if (!ok || res !== exp || ran !== !h) begin
        errors++;
        $display("FAIL flush[%0d]: res=%h ran=%0d ok=%0d, required res=%h ran=%0d",
          i, res, ran, ok, exp, !h);
      end
    end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    logic [31:0] exp;
    bit ran;
    bit ok;
    bit h;
    int lat;
    int k;
    // Kill five cycles into a long divide.
    pulse_flush();
    lat_force = 20;
    start_req(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (div_en_o !== 1'b1 || div_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL kill_run_pre: en=%0d valid=%0d, required 1 1",
        div_en_o, div_valid_o);
    end
    kill_i = 1'b1;
    #1;
    vectors++;
    if (div_valid_o !== 1'b0 || ex.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_run_same: div_valid=%0d res_valid=%0d, required 0 0",
        div_valid_o, ex.res_valid_o);
    end
    @(posedge clk); #1;
    kill_i = 1'b0;
    vectors++;
    if (ex.req_ready_o !== 1'b1 || div_en_o !== 1'b0 ||
        ex.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_run_idle: ready=%0d en=%0d res_valid=%0d, required 1 0 0",
        ex.req_ready_o, div_en_o, ex.res_valid_o);
    end
    lat_force = 0;
    h = model_step(OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
    exp = ref_div(OP_DIVU, 32'd1000, 32'd3);
    run_op(OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 0,
           res, ran, lat, ok);
    vectors++;
    if (!ok || res !== exp || ran !== !h) begin
      errors++;
      $display("FAIL kill_reissue: res=%h ran=%0d ok=%0d, required res=%h ran=%0d",
        res, ran, ok, exp, !h);
    end
    // Kill in the cycle the divider presents its result.
    pulse_flush();
    lat_force = 3;
    start_req(OP_DIVU, 32'd77, 32'd5, 1'b0);
    k = 0;
    while (!dv && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    kill_i = 1'b1;
    #1;
    vectors++;
    if (dv !== 1'b1 || div_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_hs: div_valid_i=%0d div_ready=%0d, required 1 0",
        dv, div_ready_o);
    end
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ex.res_valid_o !== 1'b0 || ex.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL kill_hs_idle: res_valid=%0d ready=%0d, required 0 1",
        ex.res_valid_o, ex.req_ready_o);
    end
    lat_force = 0;
    h = model_step(OP_DIVU, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0);
    exp = ref_div(OP_DIVU, 32'd77, 32'd5);
    run_op(OP_DIVU, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0, 0,
           res, ran, lat, ok);
    vectors++;
    if (!ok || res !== exp || ran !== !h) begin
      errors++;
      $display("FAIL kill_hs_reissue: res=%h ran=%0d ok=%0d, required res=%h ran=%0d",
        res, ran, ok, exp, !h);
    end
    // Kill while the result waits: the completed divide already filled.
    pulse_flush();
    void'(model_step(OP_REMU, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0));
    start_req(OP_REMU, 32'd77, 32'd5, 1'b0);
    k = 0;
    while (!ex.res_valid_o && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    kill_i = 1'b1;
    #1;
    vectors++;
    if (ex.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_done: res_valid=%0d, required 0", ex.res_valid_o);
    end
    @(posedge clk); #1;
    kill_i = 1'b0;
    h = model_step(OP_REMU, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0);
    exp = ref_div(OP_REMU, 32'd77, 32'd5);
    run_op(OP_REMU, 32'd77, 32'd5, 1'b0, 1'b0, 1'b0, 0,
           res, ran, lat, ok);
    vectors++;
    if (!ok || res !== exp || ran !== !h) begin
      errors++;
      $display("FAIL kill_done_reissue: res=%h ran=%0d ok=%0d, required res=%h ran=%0d",
        res, ran, ok, exp, !h);
    end
  endtask

  task automatic test_random();
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] exp;
    bit dit;
    bit fa;
    bit fh;
    bit ran;
    bit ok;
    bit h;
    int lat;
    int st;
    pa = '{32'd100, 32'h8000_0000, 32'hFFFF_FFF9, 32'd0};
    pb = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd3};
    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(3, 0));
      a   = ($urandom_range(3, 0) == 0) ? $urandom : pa[$urandom_range(3, 0)];
      b   = ($urandom_range(3, 0) == 0) ? $urandom : pb[$urandom_range(3, 0)];
      if ($urandom_range(2, 0) == 0) begin
        op = mop;
        a  = ma;
        b  = mb;
      end
      dit = ($urandom_range(4, 0) == 0);
      fa  = ($urandom_range(9, 0) == 0);
      fh  = ($urandom_range(9, 0) == 0);
      st  = $urandom_range(2, 0);
      if ($urandom_range(11, 0) == 0) pulse_flush();
      h   = model_step(op, a, b, dit, fa, fh);
      exp = ref_div(op, a, b);
      run_op(op, a, b, dit, fa, fh, st, res, ran, lat, ok);
      vectors++;
      if (!ok || res !== exp || ran !== !h) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h dit=%0d: res=%h ran=%0d lat=%0d ok=%0d, required res=%h ran=%0d",
          i, op, a, b, dit, res, ran, lat, ok, exp, !h);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res;
    logic [31:0] exp;
    bit ran;
    bit ok;
    bit h;
    int lat;
    void'(model_step(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0));
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 0,
           res, ran, lat, ok);
    lat_force = 30;
    start_req(OP_DIVU, 32'd100, 32'd9, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    mv = 1'b0;
    vectors++;
    if ({ex.req_ready_o, ex.res_valid_o, div_en_o, div_valid_o,
         div_ready_o} !== 5'b10000) begin
      errors++;
      $display("FAIL rst_mid_ctl: got %b, required 10000",
        {ex.req_ready_o, ex.res_valid_o, div_en_o, div_valid_o,
         div_ready_o});
    end
    vectors++;
    if ({ex.res_data_o, div_op_a_o, div_op_b_o, div_operator_o,
         div_dit_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_data: res=%h a=%h b=%h, required 0",
        ex.res_data_o, div_op_a_o, div_op_b_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat_force = 0;
    @(posedge clk); #1;
    h = model_step(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    exp = ref_div(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 0,
           res, ran, lat, ok);
    vectors++;
    if (!ok || res !== exp || ran !== !h) begin
      errors++;
      $display("FAIL rst_mid_cache: res=%h ran=%0d ok=%0d, required res=%h ran=%0d",
        res, ran, ok, exp, !h);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors           = 0;
    errors            = 0;
    lat_force         = 0;
    mv                = 1'b0;
    mop               = '0;
    ma                = '0;
    mb                = '0;
    mres              = '0;
    rst_n             = 1'b0;
    kill_i            = 1'b0;
    cache_flush_i     = 1'b0;
    ex.req_valid_i    = 1'b0;
    ex.req_operator_i = '0;
    ex.req_op_a_i     = '0;
    ex.req_op_b_i     = '0;
    ex.req_dit_i      = 1'b0;
    ex.res_ready_i    = 1'b0;
    test_reset();
    test_fill_hit();
    test_dit();
    test_stall();
    test_flush();
    test_kill();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
